// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples the rows,
// and debounces presses and releases over whole scans before reporting a hex key code.
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] DCNT_ONE = DW'(1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_e;

  logic [3:0]    rowMeta_q, rowSync_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    colIdx_q;
  logic [15:0]   hitMap_q, hitMap_d;
  state_e        state_q;
  logic [3:0]    cand_q, keyCode_q;
  logic [DW-1:0] dcnt_q, dcntInc_d;
  logic          keyValid_q, keyHeld_q;

  logic          tick, scanEnd, isNone, isSingle;
  logic [4:0]    hitCount;
  logic [3:0]    hitIdx, hitCode;

  function automatic logic [3:0] codeOf(input logic [3:0] idx);
    case (idx)
      4'd0:  codeOf = 4'h1;  4'd1:  codeOf = 4'h2;  4'd2:  codeOf = 4'h3;  4'd3:  codeOf = 4'hA;
      4'd4:  codeOf = 4'h4;  4'd5:  codeOf = 4'h5;  4'd6:  codeOf = 4'h6;  4'd7:  codeOf = 4'hB;
      4'd8:  codeOf = 4'h7;  4'd9:  codeOf = 4'h8;  4'd10: codeOf = 4'h9;  4'd11: codeOf = 4'hC;
      4'd12: codeOf = 4'hE;  4'd13: codeOf = 4'h0;  4'd14: codeOf = 4'hF;  default: codeOf = 4'hD;
    endcase
  endfunction

  assign tick    = (cnt_q == CNT_MAX);
  assign scanEnd = tick && (colIdx_q == 2'd3);
  assign col_n   = ~(4'b0001 << colIdx_q);

  // Hit map index is {row, column}; the current column's samples are merged in so the
  // scan-end evaluation sees all four columns including the one just finishing.
  always_comb begin
    hitMap_d = hitMap_q;
    for (int r = 0; r < 4; r++) begin
      hitMap_d[{2'(r), colIdx_q}] = ~rowSync_q[r];
    end
    hitCount = '0;
    hitIdx   = '0;
    for (int i = 0; i < 16; i++) begin
      hitCount = hitCount + 5'(hitMap_d[i]);
      if (hitMap_d[i]) hitIdx = 4'(i);
    end
    hitCode   = codeOf(hitIdx);
    isNone    = (hitCount == 5'd0);
    isSingle  = (hitCount == 5'd1);
    dcntInc_d = (dcnt_q == DCNT_MAX) ? dcnt_q : dcnt_q + DCNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowMeta_q <= 4'b1111;
      rowSync_q <= 4'b1111;
      cnt_q     <= '0;
      colIdx_q  <= 2'd0;
      hitMap_q  <= '0;
    end else begin
      rowMeta_q <= row_n;
      rowSync_q <= rowMeta_q;
      if (tick) begin
        cnt_q    <= '0;
        colIdx_q <= colIdx_q + 2'd1;
        hitMap_q <= scanEnd ? 16'h0000 : hitMap_d;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= 4'h0;
      dcnt_q     <= '0;
      keyCode_q  <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      keyValid_q <= 1'b0;
      if (scanEnd) begin
        case (state_q)
          IDLE: begin
            if (isSingle) begin
              cand_q <= hitCode;
              if (DCNT_MAX == DCNT_ONE) begin
                keyCode_q  <= hitCode;
                keyValid_q <= 1'b1;
                keyHeld_q  <= 1'b1;
                dcnt_q     <= '0;
                state_q    <= HELD;
              end else begin
                dcnt_q  <= DCNT_ONE;
                state_q <= PRESS_DEB;
              end
            end
          end
          PRESS_DEB: begin
            if (isSingle && hitCode == cand_q) begin
              if (dcntInc_d == DCNT_MAX) begin
                keyCode_q  <= cand_q;
                keyValid_q <= 1'b1;
                keyHeld_q  <= 1'b1;
                dcnt_q     <= '0;
                state_q    <= HELD;
              end else begin
                dcnt_q <= dcntInc_d;
              end
            end else if (isSingle) begin
              cand_q <= hitCode;
              dcnt_q <= DCNT_ONE;
            end else begin
              dcnt_q  <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (isNone) begin
              if (DCNT_MAX == DCNT_ONE) begin
                keyHeld_q <= 1'b0;
                dcnt_q    <= '0;
                state_q   <= IDLE;
              end else begin
                dcnt_q  <= DCNT_ONE;
                state_q <= REL_DEB;
              end
            end
          end
          REL_DEB: begin
            if (!isNone) begin
              dcnt_q  <= '0;
              state_q <= HELD;
            end else if (dcntInc_d == DCNT_MAX) begin
              keyHeld_q <= 1'b0;
              dcnt_q    <= '0;
              state_q   <= IDLE;
            end else begin
              dcnt_q <= dcntInc_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Self-checking bench for keypad_scanner_4x4: a keypad model drives the rows from the
// pressed-key set, and each scan's outputs are compared to a table or a run-length model.
module tb_keypad_scanner_4x4;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  localparam logic [15:0] K5    = 16'h0020;
  localparam logic [15:0] K9    = 16'h0400;
  localparam logic [15:0] KA    = 16'h0008;
  localparam logic [15:0] K0    = 16'h2000;
  localparam logic [15:0] KMULT = 16'h0011;

  typedef struct packed {
    logic [15:0] mask;
    logic        expValid;
    logic        expHeld;
    logic [3:0]  expCode;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rowN, colN, keyCode;
  logic        keyValid, keyHeld;
  logic [15:0] keyMask = '0;
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  codeTab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scanner_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row_n(rowN), .col_n(colN),
    .key_code(keyCode), .key_valid(keyValid), .key_held(keyHeld)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column, so a row reads low only while that column is driven.
  always_comb begin
    rowN = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keyMask[r*4+c] && !colN[c]) rowN[r] = 1'b0;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one full scan with the given pressed-key set, checking the column rotation and
  // that key_valid stays low until the scan-end edge.
  task automatic applyStimulus(input logic [15:0] mask, output logic gotValid,
                               output logic gotHeld, output logic [3:0] gotCode);
    logic [3:0] expCol;
    int         expIdx;
    keyMask = mask;
    for (int i = 1; i <= SCAN_CYC; i++) begin
      @(posedge clk);
      @(negedge clk);
      expIdx = (i / SCAN_DIV) % 4;
      expCol = ~(4'b0001 << expIdx);
      checkOutput("col_n", colN, expCol);
      if (i < SCAN_CYC) checkOutput("valid_midscan", {3'b0, keyValid}, 4'h0);
    end
    gotValid = keyValid;
    gotHeld  = keyHeld;
    gotCode  = keyCode;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_col_n", colN, 4'b1110);
    checkOutput("rst_key_code", keyCode, 4'h0);
    checkOutput("rst_key_valid", {3'b0, keyValid}, 4'h0);
    checkOutput("rst_key_held", {3'b0, keyHeld}, 4'h0);
  endtask

  initial begin
    vec_t        vecs [25];
    logic        v, h;
    logic [3:0]  c;
    logic [15:0] mask;
    logic        mHeld, mValid;
    logic [3:0]  mCand, mCode, sCode;
    int          pressRun, relRun, nHits, sel, a, b;

    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{16'h0000, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{K5,       1'b0, 1'b0, 4'h0};
    vecs[3]  = '{K5,       1'b1, 1'b1, 4'h5};
    vecs[4]  = '{K5,       1'b0, 1'b1, 4'h5};
    vecs[5]  = '{16'h0000, 1'b0, 1'b1, 4'h5};
    vecs[6]  = '{16'h0000, 1'b0, 1'b0, 4'h5};
    vecs[7]  = '{KMULT,    1'b0, 1'b0, 4'h5};
    vecs[8]  = '{KMULT,    1'b0, 1'b0, 4'h5};
    vecs[9]  = '{KMULT,    1'b0, 1'b0, 4'h5};
    vecs[10] = '{KMULT,    1'b0, 1'b0, 4'h5};
    vecs[11] = '{K9,       1'b0, 1'b0, 4'h5};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 4'h5};
    vecs[13] = '{K9,       1'b0, 1'b0, 4'h5};
    vecs[14] = '{KA,       1'b0, 1'b0, 4'h5};
    vecs[15] = '{KA,       1'b1, 1'b1, 4'hA};
    vecs[16] = '{16'h0000, 1'b0, 1'b1, 4'hA};
    vecs[17] = '{16'h0000, 1'b0, 1'b0, 4'hA};
    vecs[18] = '{K0,       1'b0, 1'b0, 4'hA};
    vecs[19] = '{K0,       1'b1, 1'b1, 4'h0};
    vecs[20] = '{16'h0000, 1'b0, 1'b1, 4'h0};
    vecs[21] = '{K0,       1'b0, 1'b1, 4'h0};
    vecs[22] = '{K0 | K5,  1'b0, 1'b1, 4'h0};
    vecs[23] = '{16'h0000, 1'b0, 1'b1, 4'h0};
    vecs[24] = '{16'h0000, 1'b0, 1'b0, 4'h0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues();
    rst = 1'b0;

    for (int k = 0; k < 25; k++) begin
      applyStimulus(vecs[k].mask, v, h, c);
      checkOutput($sformatf("vec%0d_valid", k), {3'b0, v}, {3'b0, vecs[k].expValid});
      checkOutput($sformatf("vec%0d_held", k), {3'b0, h}, {3'b0, vecs[k].expHeld});
      checkOutput($sformatf("vec%0d_code", k), c, vecs[k].expCode);
    end

    // Reset in the middle of debouncing 'A' must clear everything and restart the count.
    applyStimulus(K5, v, h, c);
    applyStimulus(K5, v, h, c);
    checkOutput("pre_rst_code", c, 4'h5);
    applyStimulus(16'h0000, v, h, c);
    applyStimulus(16'h0000, v, h, c);
    applyStimulus(KA, v, h, c);
    keyMask = KA;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(KA, v, h, c);
    checkOutput("rst_scan1_valid", {3'b0, v}, 4'h0);
    checkOutput("rst_scan1_held", {3'b0, h}, 4'h0);
    applyStimulus(KA, v, h, c);
    checkOutput("rst_scan2_valid", {3'b0, v}, 4'h1);
    checkOutput("rst_scan2_code", c, 4'hA);

    // Randomized scans compared with a run-length debounce model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mHeld = 1'b0; mCand = 4'h0; mCode = 4'h0; pressRun = 0; relRun = 0;
    mask = '0;
    for (int s = 0; s < 80; s++) begin
      if (s == 0 || $urandom_range(0, 1) == 0) begin
        sel = int'($urandom_range(0, 9));
        a   = int'($urandom_range(0, 15));
        b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
        if (sel < 3)      mask = '0;
        else if (sel < 8) mask = 16'(1) << a;
        else              mask = (16'(1) << a) | (16'(1) << b);
      end
      applyStimulus(mask, v, h, c);

      nHits = $countones(mask);
      sCode = 4'h0;
      for (int i = 0; i < 16; i++) if (mask[i]) sCode = codeTab[i];
      mValid = 1'b0;
      if (!mHeld) begin
        if (nHits == 1 && pressRun > 0 && sCode == mCand) pressRun++;
        else if (nHits == 1) begin pressRun = 1; mCand = sCode; end
        else pressRun = 0;
        if (pressRun == DEB) begin
          mValid = 1'b1; mHeld = 1'b1; mCode = mCand; pressRun = 0; relRun = 0;
        end
      end else begin
        if (nHits == 0) relRun++; else relRun = 0;
        if (relRun == DEB) begin mHeld = 1'b0; relRun = 0; end
      end

      checkOutput($sformatf("rnd%0d_valid", s), {3'b0, v}, {3'b0, mValid});
      checkOutput($sformatf("rnd%0d_held", s), {3'b0, h}, {3'b0, mHeld});
      checkOutput($sformatf("rnd%0d_code", s), c, mCode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
- Input-side counterpart of the two-digit multiplexed 7-segment driver.
- The display driver scans outputs; this block scans a 4x4 matrix keypad. It drives one active-low column at a time, samples the active-low rows, and debounces over whole scans.
- It presents a 4-bit hex key code with a one-cycle valid strobe to the data-entry logic that feeds the Hamming encoder.

Parameters:
- SCAN_DIV, 27000, clock cycles each column stays driven (must be >= 4).
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release (must be >= 1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- row_n  input  4  keypad rows, active-low, asynchronous to clk (external pull-ups)
- col_n  output  4  keypad columns, active-low one-hot drive
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset values (asynchronous, immediate): col_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0. Scan counter, column index, debounce counter and FSM are cleared; FSM=IDLE. Reset mid-scan or mid-debounce discards all partial state.
- Synchronizer: row_n passes through a 2-flop synchronizer (reset to 4'b1111) before any use.
- Column timing:
  - Counter runs 0..SCAN_DIV-1; tick = (cnt==SCAN_DIV-1).
  - On tick the column index advances 0→1→2→3→0 and col_n rotates: col0=1110, col1=1101, col2=1011, col3=0111.
  - The synchronized rows are sampled on the tick cycle, i.e. the last cycle of the current column period.
- Full scan: one scan = 4 column periods = 4*SCAN_DIV cycles. Per-column row samples accumulate into a 16-bit hit map, which is evaluated on the tick that ends column 3.
- Scan result classes: NONE (0 hits), SINGLE (exactly 1 hit, with its code), MULTI (≥2 hits).
- Code map (row r = row_n[r], column c = col_n[c]):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D (* = E, # = F)
- FSM, evaluated only at scan end:
  - IDLE:
    - SINGLE → PRESS_DEB, candidate=code, dcnt=1.
    - Else stay.
    - If DEBOUNCE_SCANS==1, go directly to accept.
  - PRESS_DEB:
    - SINGLE with same code: dcnt++. When dcnt reaches DEBOUNCE_SCANS, accept: key_code<=candidate, key_valid=1 for exactly one cycle, key_held<=1, → HELD.
    - SINGLE with a different code: restart with the new candidate, dcnt=1.
    - NONE or MULTI: → IDLE, dcnt=0.
  - HELD:
    - NONE → REL_DEB, dcnt=1.
    - SINGLE (any code) or MULTI: stay. No auto-repeat; rollover to a second key is not reported until full release.
  - REL_DEB:
    - NONE: dcnt++. At DEBOUNCE_SCANS: key_held<=0, → IDLE.
    - SINGLE or MULTI: → HELD, dcnt=0.
- Outputs:
  - key_valid and key_held change on the same clock edge as the accepting or releasing scan-end tick.
  - key_code holds its value until the next accepted press.
- Latency:
  - Press: accepted at the end of scan DEBOUNCE_SCANS counted from the first scan that saw the key. A key appearing mid-scan is counted only from a scan whose sample caught it.
  - Release: same rule applies.
- Counter widths:
  - Column counter uses $clog2(SCAN_DIV) bits.
  - dcnt saturates and never wraps.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; scan = 16 cycles):
- Reset then idle with row_n=4'b1111:
  - col_n sequence is 1110,1101,1011,0111 repeating, each held 4 cycles.
  - key_valid never asserts; key_held=0.
- Hold row_n[1] low only while col_n=4'b1101 (key '5') for 3 scans:
  - Exactly one key_valid pulse at the end of the 2nd scan, with key_code=4'h5.
  - key_held=1 from that cycle.
- Glitch on key '9' (row2/col2) present for 1 scan only: no key_valid; FSM returns to IDLE.
- Release scenario: hold '0' (row3/col1) until accepted, then release.
  - key_held falls at the end of the 2nd all-NONE scan.
  - A 1-scan release followed by re-press keeps key_held=1 with no new key_valid.
- Two keys pressed simultaneously (rows 0 and 1 on col0) from IDLE for 4 scans: MULTI, no key_valid, key_code unchanged.
- Assert rst for 1 cycle during PRESS_DEB of key 'A':
  - All outputs return to reset values immediately.
  - Press detection restarts from scratch; key_valid occurs 2 full scans after release of rst.
